// File: rtl/instruction_decode_stage.sv
// instruction_decode_stage: decode stage with 8-entry register file, jump redirect/squash and ID/EX valid/ready bundle
// Ports:
//   clk, reset                        clock and synchronous active-high reset
//   if_valid, if_pc, Opcode, Rd, Rs,
//   Partial_Address, if_ready         fetch beat in, backpressure out
//   wb_en, wb_addr, wb_data           register file writeback
//   ex_ready, id_valid, id_opcode, id_rd,
//   id_rd_data, id_rs_data, id_reg_write  ID/EX bundle toward execute
//   jump_taken, jump_target           one-cycle PC redirect
module instruction_decode_stage #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [PC_W-1:0]   if_pc,
  input  logic [1:0]        Opcode,
  input  logic [REG_AW-1:0] Rd,
  input  logic [REG_AW-1:0] Rs,
  input  logic [5:0]        Partial_Address,
  output logic              if_ready,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_ready,
  output logic              id_valid,
  output logic [1:0]        id_opcode,
  output logic [REG_AW-1:0] id_rd,
  output logic [DATA_W-1:0] id_rd_data,
  output logic [DATA_W-1:0] id_rs_data,
  output logic              id_reg_write,
  output logic              jump_taken,
  output logic [PC_W-1:0]   jump_target
);
  localparam int NREG = 2 ** REG_AW;
  localparam logic [PC_W-1:0] PC_HI_MASK = {{(PC_W-6){1'b1}}, 6'b0};
  logic [DATA_W-1:0] r_q [NREG];
  logic              id_valid_q, id_valid_d;
  logic              id_reg_write_q, id_reg_write_d;
  logic [1:0]        id_opcode_q, id_opcode_d;
  logic [REG_AW-1:0] id_rd_q, id_rd_d;
  logic [DATA_W-1:0] id_rd_data_q, id_rd_data_d;
  logic [DATA_W-1:0] id_rs_data_q, id_rs_data_d;
  logic              jump_taken_q, jump_taken_d;
  logic [PC_W-1:0]   jump_target_q, jump_target_d;
  logic              squash_q, squash_d;
  logic              accept, take_jump;
  logic [DATA_W-1:0] rd_val, rs_val;
  assign if_ready  = ~id_valid_q | ex_ready;
  assign accept    = if_valid & if_ready;
  // a beat in the shadow of a taken jump is wrong-path and never redirects
  assign take_jump = accept & ~squash_q & (Opcode == 2'b11);
  // write-through: a same-cycle writeback is visible to the read
  assign rd_val = (wb_en && wb_addr == Rd) ? wb_data : r_q[Rd];
  assign rs_val = (wb_en && wb_addr == Rs) ? wb_data : r_q[Rs];
  always_comb begin
    id_valid_d     = accept ? (~squash_q & (Opcode != 2'b11)) : (ex_ready ? 1'b0 : id_valid_q);
    id_reg_write_d = accept ? (~squash_q & ~Opcode[1]) : (ex_ready ? 1'b0 : id_reg_write_q);
    id_opcode_d    = accept ? Opcode : id_opcode_q;
    id_rd_d        = accept ? Rd : id_rd_q;
    id_rd_data_d   = accept ? rd_val : id_rd_data_q;
    id_rs_data_d   = accept ? rs_val : id_rs_data_q;
    jump_taken_d   = take_jump;
    squash_d       = take_jump;
    jump_target_d  = take_jump ? ((if_pc & PC_HI_MASK) | PC_W'(Partial_Address)) : jump_target_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_q[i] <= DATA_W'(i);
      id_valid_q     <= 1'b0;
      id_reg_write_q <= 1'b0;
      id_opcode_q    <= '0;
      id_rd_q        <= '0;
      id_rd_data_q   <= '0;
      id_rs_data_q   <= '0;
      jump_taken_q   <= 1'b0;
      jump_target_q  <= '0;
      squash_q       <= 1'b0;
    end else begin
      if (wb_en) r_q[wb_addr] <= wb_data;
      id_valid_q     <= id_valid_d;
      id_reg_write_q <= id_reg_write_d;
      id_opcode_q    <= id_opcode_d;
      id_rd_q        <= id_rd_d;
      id_rd_data_q   <= id_rd_data_d;
      id_rs_data_q   <= id_rs_data_d;
      jump_taken_q   <= jump_taken_d;
      jump_target_q  <= jump_target_d;
      squash_q       <= squash_d;
    end
  end
  assign id_valid     = id_valid_q;
  assign id_reg_write = id_reg_write_q;
  assign id_opcode    = id_opcode_q;
  assign id_rd        = id_rd_q;
  assign id_rd_data   = id_rd_data_q;
  assign id_rs_data   = id_rs_data_q;
  assign jump_taken   = jump_taken_q;
  assign jump_target  = jump_target_q;
endmodule
